// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_stage_pkg;

  localparam int unsigned INSTR_W          = 32;
  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Bundle of memory, redirect, decode-handshake and status signals of the fetch stage.
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic [31:0]        imem_addr;
  logic [INSTR_W-1:0] imem_instr;
  logic               redirect_valid;
  logic [31:0]        redirect_target;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [31:0]        out_pc;
  logic [31:0]        out_pc_plus4;
  logic               fetch_err;
  logic [31:0]        fetch_count;

  modport master (
    output imem_addr, out_valid, out_instr, out_pc, out_pc_plus4, fetch_err, fetch_count,
    input  imem_instr, redirect_valid, redirect_target, out_ready
  );

  modport slave (
    input  imem_addr, out_valid, out_instr, out_pc, out_pc_plus4, fetch_err, fetch_count,
    output imem_instr, redirect_valid, redirect_target, out_ready
  );

endinterface

// File: rtl/fetch_stage_out_reg.sv
// Valid/ready output register of the fetch stage: holds instr, pc and pc+4.
module fetch_out_reg
  import fetch_stage_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic               flush_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [31:0]        pc_i,
  output logic               valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [31:0]        pc_o,
  output logic [31:0]        pc_plus4_o
);

  logic               valid_q;
  logic [INSTR_W-1:0] instr_q;
  logic [31:0]        pc_q;
  logic [31:0]        pc_plus4_q;

  // Flush only drops valid; the stale payload is harmless and saves muxing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      instr_q    <= '0;
      pc_q       <= '0;
      pc_plus4_q <= '0;
    end else if (flush_i) begin
      valid_q    <= 1'b0;
    end else if (load_i) begin
      valid_q    <= 1'b1;
      instr_q    <= instr_i;
      pc_q       <= pc_i;
      pc_plus4_q <= pc_i + PC_INC;
    end
  end

  assign valid_o    = valid_q;
  assign instr_o    = instr_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives imem, and presents instructions to decode.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned IMEM_BYTES = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.master bus
);

  localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_BYTES);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  count_q, count_d;
  logic         load_o, flush_o;
  logic         out_valid;
  logic         fire, load, redir_bad;

  assign fire      = (state_q == RUN) && out_valid && bus.out_ready;
  assign load      = !out_valid || bus.out_ready;
  assign redir_bad = (bus.redirect_target[1:0] != 2'b00) || (bus.redirect_target >= IMEM_LIMIT);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    load_o  = 1'b0;
    flush_o = 1'b0;
    count_d = count_q + 32'(fire);
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (bus.redirect_valid && redir_bad) begin
          state_d = ERR;
          flush_o = 1'b1;
        end else if (bus.redirect_valid) begin
          pc_d    = bus.redirect_target;
          flush_o = 1'b1;
        end else if (load) begin
          // pc only leaves the legal range by stepping past the last word.
          if (pc_q >= IMEM_LIMIT) begin
            state_d = ERR;
            flush_o = 1'b1;
          end else begin
            load_o = 1'b1;
            pc_d   = pc_q + PC_INC;
          end
        end
      end
      ERR:     flush_o = 1'b1;
      default: state_d = ERR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  fetch_out_reg u_out_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (load_o),
    .flush_i    (flush_o),
    .instr_i    (bus.imem_instr),
    .pc_i       (pc_q),
    .valid_o    (out_valid),
    .instr_o    (bus.out_instr),
    .pc_o       (bus.out_pc),
    .pc_plus4_o (bus.out_pc_plus4)
  );

  assign bus.out_valid   = out_valid;
  assign bus.imem_addr   = pc_q;
  assign bus.fetch_err   = (state_q == ERR);
  assign bus.fetch_count = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: expected fetches are queued and popped on each handshake.
module tb_fetch_stage;

  logic clk = 1'b0;
  logic rst_n;

  fetch_stage_if bus ();

  fetch_stage #(.RESET_PC(32'h0000_0000), .IMEM_BYTES(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:7];
  logic [31:0] sb [$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  initial begin
    mem[0] = 32'h0090_0493; mem[1] = 32'h0050_0293;
    mem[2] = 32'hfe54_ae23; mem[3] = 32'hffc4_a303;
    mem[4] = 32'h0012_8293; mem[5] = 32'hfe5f_f06f;
    mem[6] = 32'h0000_0013; mem[7] = 32'h0000_006f;
  end

  always_comb begin
    bus.imem_instr = 32'hdead_beef;
    if (bus.imem_addr < 32'd32) bus.imem_instr = mem[bus.imem_addr[4:2]];
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_seq(input logic [31:0] start, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) sb.push_back(start + 32'(4 * i));
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
    check_eq({tag, "_instr"}, bus.out_instr, 32'd0);
    check_eq({tag, "_pc"}, bus.out_pc, 32'd0);
    check_eq({tag, "_pc4"}, bus.out_pc_plus4, 32'd0);
    check_eq({tag, "_err"}, 32'(bus.fetch_err), 32'd0);
    check_eq({tag, "_count"}, bus.fetch_count, 32'd0);
    check_eq({tag, "_addr"}, bus.imem_addr, 32'd0);
  endtask

  // A handshake seen here completes at the next rising edge.
  always @(negedge clk) begin
    logic [31:0] e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      check_eq("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check_eq("sb_pc", bus.out_pc, e);
        check_eq("sb_instr", bus.out_instr, mem[e[4:2]]);
        check_eq("sb_pc4", bus.out_pc_plus4, e + 32'd4);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n               = 1'b0;
    bus.out_ready       = 1'b1;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = 32'd0;
    tick();
    tick();
    check_reset("rst0");

    // Boot and sequential fetch
    push_seq(32'd0, 4);
    rst_n = 1'b1;
    tick();
    check_eq("boot_valid", 32'(bus.out_valid), 32'd0);
    tick();
    check_eq("first_valid", 32'(bus.out_valid), 32'd1);
    check_eq("first_instr", bus.out_instr, 32'h0090_0493);
    check_eq("first_pc", bus.out_pc, 32'd0);
    tick();
    check_eq("second_instr", bus.out_instr, 32'h0050_0293);
    check_eq("second_pc", bus.out_pc, 32'd4);
    check_eq("second_pc4", bus.out_pc_plus4, 32'd8);
    tick();
    check_eq("pre_stall_pc", bus.out_pc, 32'd8);

    // Stall at out_pc=8
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("stall_instr", bus.out_instr, 32'hfe54_ae23);
      check_eq("stall_addr", bus.imem_addr, 32'd12);
      check_eq("stall_count", bus.fetch_count, 32'd2);
    end
    bus.out_ready = 1'b1;
    tick();
    check_eq("unstall_pc", bus.out_pc, 32'd12);
    check_eq("unstall_instr", bus.out_instr, 32'hffc4_a303);
    check_eq("unstall_count", bus.fetch_count, 32'd3);

    // Redirect overriding a stall
    bus.out_ready       = 1'b0;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'd4;
    tick();
    bus.redirect_valid = 1'b0;
    sb.delete();
    push_seq(32'd4, 2);
    check_eq("redir_flush", 32'(bus.out_valid), 32'd0);
    check_eq("redir_addr", bus.imem_addr, 32'd4);
    bus.out_ready = 1'b1;
    tick();
    check_eq("redir_valid", 32'(bus.out_valid), 32'd1);
    check_eq("redir_pc", bus.out_pc, 32'd4);
    check_eq("redir_instr", bus.out_instr, 32'h0050_0293);
    check_eq("redir_count", bus.fetch_count, 32'd3);
    tick();
    check_eq("post_redir_pc", bus.out_pc, 32'd8);

    // Misaligned redirect, with a simultaneous accepted handshake
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'd6;
    tick();
    bus.redirect_target = 32'd0;
    check_eq("mis_err", 32'(bus.fetch_err), 32'd1);
    check_eq("mis_valid", 32'(bus.out_valid), 32'd0);
    check_eq("mis_count", bus.fetch_count, 32'd5);
    check_eq("mis_drained", 32'(sb.size()), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("err_sticky", 32'(bus.fetch_err), 32'd1);
      check_eq("err_valid", 32'(bus.out_valid), 32'd0);
      check_eq("err_addr", bus.imem_addr, 32'd12);
      check_eq("err_count", bus.fetch_count, 32'd5);
    end
    bus.redirect_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("rst_err");
    sb.delete();
    tick();

    // Sequential run off the end of memory
    push_seq(32'd0, 8);
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    check_eq("last_valid", 32'(bus.out_valid), 32'd1);
    check_eq("last_pc", bus.out_pc, 32'd28);
    check_eq("last_instr", bus.out_instr, 32'h0000_006f);
    check_eq("last_err", 32'(bus.fetch_err), 32'd0);
    tick();
    check_eq("range_err", 32'(bus.fetch_err), 32'd1);
    check_eq("range_valid", 32'(bus.out_valid), 32'd0);
    check_eq("range_addr", bus.imem_addr, 32'd32);
    check_eq("range_count", bus.fetch_count, 32'd8);
    check_eq("range_drained", 32'(sb.size()), 32'd0);

    // Async reset in the middle of a stall
    rst_n = 1'b0;
    #1;
    sb.delete();
    tick();
    push_seq(32'd0, 3);
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    check_eq("pre_async_pc", bus.out_pc, 32'd4);
    bus.out_ready = 1'b0;
    tick();
    tick();
    check_eq("pre_async_valid", 32'(bus.out_valid), 32'd1);
    check_eq("pre_async_count", bus.fetch_count, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("rst_async");
    sb.delete();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
